// File: rtl/reg_file_pkg.sv
// Shared constants and byte-lane helpers for the multi-port register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int MAX_W      = 256;
  localparam int MAX_BE     = MAX_W / 8;

  function automatic int byte_lanes(input int w);
    return w / 8;
  endfunction

  // Operates on the widest supported word; callers widen/narrow with size casts.
  function automatic logic [MAX_W-1:0] merge_bytes(input logic [MAX_W-1:0]  old_v,
                                                    input logic [MAX_W-1:0]  new_v,
                                                    input logic [MAX_BE-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_v;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: range check, zero register, write bypass and optional output register.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  parameter int REG_OUT  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       raddr,
  input  logic [DEPTH*DATA_W-1:0] mem_flat,
  input  logic [DEPTH-1:0]        written,
  input  logic                    wr0_ok,
  input  logic [ADDR_W-1:0]       waddr0,
  input  logic [DATA_W/8-1:0]     wbe0,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic                    wr1_ok,
  input  logic [ADDR_W-1:0]       waddr1,
  input  logic [DATA_W/8-1:0]     wbe1,
  input  logic [DATA_W-1:0]       wdata1,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid
);

  logic [DATA_W-1:0] rd_c, rd_q;
  logic              rv_c, rv_q;

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0]   o,
                                                     input logic [DATA_W-1:0]   n,
                                                     input logic [DATA_W/8-1:0] be);
    return DATA_W'(merge_bytes(MAX_W'(o), MAX_W'(n), MAX_BE'(be)));
  endfunction

  // Port 1 is merged last so it overrides port 0 on shared bytes.
  always_comb begin
    rd_c = '0;
    rv_c = 1'b0;
    if (int'(raddr) < DEPTH) begin
      if (ZERO_REG != 0 && raddr == '0) begin
        rv_c = 1'b1;
      end else begin
        rd_c = mem_flat[int'(raddr)*DATA_W +: DATA_W];
        rv_c = written[int'(raddr)];
        if (BYPASS != 0) begin
          if (wr0_ok && waddr0 == raddr) begin
            rd_c = merge_lanes(rd_c, wdata0, wbe0);
            rv_c = rv_c | (|wbe0);
          end
          if (wr1_ok && waddr1 == raddr) begin
            rd_c = merge_lanes(rd_c, wdata1, wbe1);
            rv_c = rv_c | (|wbe1);
          end
        end
      end
    end
  end

  // Flops are pruned by synthesis when the combinational path is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rd_q <= rd_c;
      rv_q <= rv_c;
    end
  end

  assign rdata  = (REG_OUT != 0) ? rd_q : rd_c;
  assign rvalid = (REG_OUT != 0) ? rv_q : rv_c;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two byte-enabled write ports, NUM_RD read ports,
// per-register written-since-reset flags.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 16,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  parameter int REG_OUT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W/8-1:0]      wbe0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W/8-1:0]      wbe1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid
);

  localparam int NB = byte_lanes(DATA_W);

  logic [DATA_W-1:0]       mem     [DEPTH];
  logic [DATA_W-1:0]       mem_nxt [DEPTH];
  logic [DEPTH-1:0]        written, written_nxt;
  logic [DEPTH*DATA_W-1:0] mem_flat;
  logic                    wr0_ok, wr1_ok;

  function automatic logic target_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] o,
                                                     input logic [DATA_W-1:0] n,
                                                     input logic [NB-1:0]     be);
    return DATA_W'(merge_bytes(MAX_W'(o), MAX_W'(n), MAX_BE'(be)));
  endfunction

  // Gating with rst_n keeps the bypass path quiet while reset is held.
  assign wr0_ok = rst_n && we0 && target_ok(waddr0);
  assign wr1_ok = rst_n && we1 && target_ok(waddr1);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt[i]     = mem[i];
      written_nxt[i] = written[i];
      if (wr0_ok && int'(waddr0) == i) begin
        mem_nxt[i]     = merge_lanes(mem_nxt[i], wdata0, wbe0);
        written_nxt[i] = written_nxt[i] | (|wbe0);
      end
      if (wr1_ok && int'(waddr1) == i) begin
        mem_nxt[i]     = merge_lanes(mem_nxt[i], wdata1, wbe1);
        written_nxt[i] = written_nxt[i] | (|wbe1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
      written <= written_nxt;
    end
  end

  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < DEPTH; i++) mem_flat[i*DATA_W +: DATA_W] = mem[i];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .REG_OUT  (REG_OUT)
    ) u_rd (
      .clk      (clk),
      .rst_n    (rst_n),
      .raddr    (raddr[k*ADDR_W +: ADDR_W]),
      .mem_flat (mem_flat),
      .written  (written),
      .wr0_ok   (wr0_ok),
      .waddr0   (waddr0),
      .wbe0     (wbe0),
      .wdata0   (wdata0),
      .wr1_ok   (wr1_ok),
      .waddr1   (waddr1),
      .wbe1     (wbe1),
      .wdata1   (wdata1),
      .rdata    (rdata[k*DATA_W +: DATA_W]),
      .rvalid   (rvalid[k])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a default instance and a registered/zero-reg/short-depth
// instance share stimulus and are compared against a word-level model.
module tb_reg_file_mp;

  logic        clk;
  logic        rst_n;
  logic        we0, we1;
  logic [3:0]  waddr0, waddr1;
  logic [1:0]  wbe0, wbe1;
  logic [15:0] wdata0, wdata1;
  logic [3:0]  ra0, ra1;
  logic [7:0]  raddr;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rvalid0, rvalid1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we0;
    logic [3:0]  waddr0;
    logic [1:0]  wbe0;
    logic [15:0] wdata0;
    logic        we1;
    logic [3:0]  waddr1;
    logic [1:0]  wbe1;
    logic [15:0] wdata1;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [1:0]  expv;
  } vec_t;

  // Model state: index 0 = default instance, 1 = DEPTH 12 / zero reg / no bypass / registered.
  logic [15:0] mm [2][16];
  logic        mw [2][16];
  logic [15:0] exp1q_d [2];
  logic        exp1q_v [2];
  int cfg_depth [2] = '{16, 12};
  int cfg_zero  [2] = '{0, 1};
  int cfg_byp   [2] = '{1, 0};

  vec_t tbl [16];

  assign raddr = {ra1, ra0};

  reg_file_mp #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .NUM_RD(2),
                .ZERO_REG(0), .BYPASS(1), .REG_OUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wbe0(wbe0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wbe1(wbe1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .NUM_RD(2),
                .ZERO_REG(1), .BYPASS(0), .REG_OUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wbe0(wbe0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wbe1(wbe1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t vec(input logic e0, input int a0, input int b0, input int d0,
                               input logic e1, input int a1, input int b1, input int d1,
                               input int r0, input int r1, input int x0, input int x1,
                               input int xv);
    vec_t v;
    v.we0 = e0; v.waddr0 = 4'(a0); v.wbe0 = 2'(b0); v.wdata0 = 16'(d0);
    v.we1 = e1; v.waddr1 = 4'(a1); v.wbe1 = 2'(b1); v.wdata1 = 16'(d1);
    v.ra0 = 4'(r0); v.ra1 = 4'(r1);
    v.exp0 = 16'(x0); v.exp1 = 16'(x1); v.expv = 2'(xv);
    return v;
  endfunction

  // Word the register at address a would hold after this cycle's writes.
  function automatic void incoming(input int a, input logic [15:0] old,
                                   output logic [15:0] nv, output logic touched);
    nv = old;
    touched = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (we1 && int'(waddr1) == a && wbe1[b]) begin
        nv[b*8 +: 8] = wdata1[b*8 +: 8];
        touched = 1'b1;
      end else if (we0 && int'(waddr0) == a && wbe0[b]) begin
        nv[b*8 +: 8] = wdata0[b*8 +: 8];
        touched = 1'b1;
      end
    end
  endfunction

  function automatic void model_read(input int c, input int a,
                                     output logic [15:0] d, output logic v);
    logic [15:0] nv;
    logic        t;
    d = '0;
    v = 1'b0;
    if (a >= cfg_depth[c]) return;
    if (cfg_zero[c] != 0 && a == 0) begin
      v = 1'b1;
      return;
    end
    d = mm[c][a];
    v = mw[c][a];
    if (cfg_byp[c] != 0 && rst_n) begin
      incoming(a, d, nv, t);
      d = nv;
      v = v | t;
    end
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++) begin
        mm[c][a] = '0;
        mw[c][a] = 1'b0;
      end
    for (int p = 0; p < 2; p++) begin
      exp1q_d[p] = '0;
      exp1q_v[p] = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    we0 = v.we0; waddr0 = v.waddr0; wbe0 = v.wbe0; wdata0 = v.wdata0;
    we1 = v.we1; waddr1 = v.waddr1; wbe1 = v.wbe1; wdata1 = v.wdata1;
    ra0 = v.ra0; ra1 = v.ra1;
  endtask

  task automatic set_idle();
    we0 = 1'b0; waddr0 = '0; wbe0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wbe1 = '0; wdata1 = '0;
  endtask

  task automatic checkModel(input string tag);
    logic [15:0] d;
    logic        v;
    logic [3:0]  ra [2];
    ra[0] = ra0;
    ra[1] = ra1;
    for (int p = 0; p < 2; p++) begin
      model_read(0, int'(ra[p]), d, v);
      checkOutput({tag, "_dut0_data"}, rdata0[p*16 +: 16], d);
      checkOutput({tag, "_dut0_valid"}, 16'(rvalid0[p]), 16'(v));
      checkOutput({tag, "_dut1_data"}, rdata1[p*16 +: 16], exp1q_d[p]);
      checkOutput({tag, "_dut1_valid"}, 16'(rvalid1[p]), 16'(exp1q_v[p]));
    end
  endtask

  // Advance one clock: the model and the registered-read expectation follow the edge.
  task automatic tick();
    logic [15:0] nd [2][16];
    logic        nt [2][16];
    logic [15:0] qd [2];
    logic        qv [2];
    logic [15:0] d;
    logic        v;
    logic [3:0]  ra [2];
    ra[0] = ra0;
    ra[1] = ra1;
    for (int p = 0; p < 2; p++) model_read(1, int'(ra[p]), qd[p], qv[p]);
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++) begin
        nd[c][a] = mm[c][a];
        nt[c][a] = mw[c][a];
        if (a < cfg_depth[c] && !(cfg_zero[c] != 0 && a == 0)) begin
          incoming(a, mm[c][a], d, v);
          nd[c][a] = d;
          nt[c][a] = mw[c][a] | v;
        end
      end
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      mm = nd;
      mw = nt;
      exp1q_d = qd;
      exp1q_v = qv;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    ra0 = 4'd2;
    ra1 = 4'd7;
    model_clear();

    //         we0 a0 be d0       we1 a1 be d1      ra0 ra1 exp0    exp1    v
    tbl[0]  = vec(0, 0, 0, 0,      0, 0, 0, 0,      2,  7,  0,      0,      0);
    tbl[1]  = vec(1, 2, 3, 'h1234, 0, 0, 0, 0,      2,  7,  'h1234, 0,      1);
    tbl[2]  = vec(1, 7, 3, 'hABCD, 0, 0, 0, 0,      2,  7,  'h1234, 'hABCD, 3);
    tbl[3]  = vec(0, 0, 0, 0,      0, 0, 0, 0,      2,  7,  'h1234, 'hABCD, 3);
    tbl[4]  = vec(1, 5, 3, 'hAAAA, 0, 0, 0, 0,      5,  5,  'hAAAA, 'hAAAA, 3);
    tbl[5]  = vec(1, 5, 3, 'h1111, 1, 5, 2, 'h2200, 5,  5,  'h2211, 'h2211, 3);
    tbl[6]  = vec(0, 0, 0, 0,      0, 0, 0, 0,      5,  5,  'h2211, 'h2211, 3);
    tbl[7]  = vec(1, 15, 3, 'hF00D, 0, 0, 0, 0,     15, 15, 'hF00D, 'hF00D, 3);
    tbl[8]  = vec(1, 3, 0, 'hFFFF, 0, 0, 0, 0,      3,  15, 0,      'hF00D, 2);
    tbl[9]  = vec(0, 0, 0, 0,      0, 0, 0, 0,      3,  3,  0,      0,      0);
    tbl[10] = vec(1, 9, 2, 'h5600, 1, 9, 1, 'h1234, 9,  2,  'h5634, 'h1234, 3);
    tbl[11] = vec(1, 2, 1, 'h00EE, 0, 0, 0, 0,      2,  9,  'h12EE, 'h5634, 3);
    tbl[12] = vec(1, 4, 3, 'h4444, 1, 6, 3, 'h6666, 6,  4,  'h6666, 'h4444, 3);
    tbl[13] = vec(0, 0, 0, 0,      0, 0, 0, 0,      4,  6,  'h4444, 'h6666, 3);
    tbl[14] = vec(1, 2, 3, 'h8888, 1, 2, 3, 'h7777, 2,  2,  'h7777, 'h7777, 3);
    tbl[15] = vec(0, 0, 0, 0,      0, 0, 0, 0,      2,  0,  'h7777, 0,      1);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i]);
      #2;
      checkOutput($sformatf("tbl%0d_port0", i), rdata0[15:0], tbl[i].exp0);
      checkOutput($sformatf("tbl%0d_port1", i), rdata0[31:16], tbl[i].exp1);
      checkOutput($sformatf("tbl%0d_rvalid", i), 16'(rvalid0), 16'(tbl[i].expv));
      checkModel($sformatf("tbl%0d", i));
      tick();
    end

    // Zero register and out-of-range write on the short-depth instance.
    set_idle();
    we0 = 1'b1; waddr0 = 4'd0;  wbe0 = 2'b11; wdata0 = 16'hBEEF;
    we1 = 1'b1; waddr1 = 4'd13; wbe1 = 2'b11; wdata1 = 16'h1313;
    ra0 = 4'd0; ra1 = 4'd13;
    #2; checkModel("zr_wr");
    tick();
    set_idle();
    #2;
    checkOutput("reg0_dut0", rdata0[15:0], 16'hBEEF);
    checkOutput("reg13_dut0", rdata0[31:16], 16'h1313);
    checkModel("zr_idle");
    tick();
    #2;
    checkOutput("zero_reg_data", rdata1[15:0], 16'h0000);
    checkOutput("zero_reg_valid", 16'(rvalid1[0]), 16'h1);
    checkOutput("oor_data", rdata1[31:16], 16'h0000);
    checkOutput("oor_valid", 16'(rvalid1[1]), 16'h0);

    // Registered read latency.
    set_idle();
    we0 = 1'b1; waddr0 = 4'd8; wbe0 = 2'b11; wdata0 = 16'h1234;
    ra0 = 4'd3; ra1 = 4'd3;
    #2; checkModel("lat_wr");
    tick();
    set_idle();
    ra0 = 4'd8;
    #2;
    checkOutput("lat_before", rdata1[15:0], 16'h0000);
    checkModel("lat_mid");
    tick();
    #2;
    checkOutput("lat_after_data", rdata1[15:0], 16'h1234);
    checkOutput("lat_after_valid", 16'(rvalid1[0]), 16'h1);

    // Asynchronous reset between edges, with a write pending across the edge.
    rst_n = 1'b0;
    #1;
    checkOutput("arst_dut1_lo", rdata1[15:0], 16'h0000);
    checkOutput("arst_dut1_hi", rdata1[31:16], 16'h0000);
    checkOutput("arst_dut1_valid", 16'(rvalid1), 16'h0);
    checkOutput("arst_dut0_data", rdata0[15:0], 16'h0000);
    checkOutput("arst_dut0_valid", 16'(rvalid0[0]), 16'h0);
    model_clear();
    we0 = 1'b1; waddr0 = 4'd8; wbe0 = 2'b11; wdata0 = 16'h5555;
    #1;
    checkOutput("arst_no_bypass", rdata0[15:0], 16'h0000);
    tick();
    rst_n = 1'b1;
    we0 = 1'b1; waddr0 = 4'd8; wbe0 = 2'b01; wdata0 = 16'h9999;
    ra0 = 4'd8; ra1 = 4'd8;
    #2;
    checkOutput("post_rst_bypass", rdata0[15:0], 16'h0099);
    checkModel("post_rst_wr");
    tick();
    set_idle();
    #2;
    checkOutput("first_edge_data", rdata0[15:0], 16'h0099);
    checkOutput("first_edge_valid", 16'(rvalid0[0]), 16'h1);
    checkModel("post_rst_idle");
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      waddr0 = 4'($urandom_range(0, 15));
      waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : 4'($urandom_range(0, 15));
      wbe0   = 2'($urandom_range(0, 3));
      wbe1   = 2'($urandom_range(0, 3));
      wdata0 = 16'($urandom);
      wdata1 = 16'($urandom);
      ra0    = ($urandom_range(0, 2) == 0) ? waddr0 : 4'($urandom_range(0, 15));
      ra1    = ($urandom_range(0, 2) == 0) ? waddr1 : 4'($urandom_range(0, 15));
      #2;
      checkModel($sformatf("rnd%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
